// File: rtl/layer_output_packer_pkg.sv
// Shared definitions for the layer output packer: state encoding and width helper.
package layer_output_packer_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EMIT    = 2'd1,
    HOLDOFF = 2'd2
  } pack_state_e;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/layer_output_packer.sv
// Collects serial neuron results into a packed vector, emits it with a one-cycle
// valid pulse, then holds off new input while the downstream argmax scans it.
//
// state   | meaning
// COLLECT | accepting words into slot wr_ptr
// EMIT    | o_data_valid high for one cycle, vector complete
// HOLDOFF | waiting holdoffCycles cycles before accepting the next vector
module layer_output_packer
  import layer_output_packer_pkg::*;
#(
  parameter int numInput      = 10,
  parameter int inputWidth    = 16,
  parameter int holdoffCycles = numInput + 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [inputWidth-1:0]          i_data,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic                           i_clear,
  output logic [numInput*inputWidth-1:0] o_data,
  output logic                           o_data_valid
);

  localparam int PTR_W  = clog2_min1(numInput);
  localparam int CNT_W  = clog2_min1(holdoffCycles + 1);
  localparam int DATA_W = numInput * inputWidth;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(numInput - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((holdoffCycles > 0) ? holdoffCycles - 1 : 0);

  pack_state_e        state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [DATA_W-1:0]  data_d;
  logic               valid_d;
  logic               xfer;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    data_d     = o_data;
    valid_d    = 1'b0;
    xfer       = i_valid & o_ready;

    case (state_q)
      COLLECT: begin
        // Clear takes priority over any transfer in the same cycle.
        if (i_clear) begin
          wr_ptr_d = '0;
        end else if (xfer) begin
          for (int n = 0; n < numInput; n++) begin
            if (wr_ptr_q == PTR_W'(n)) data_d[n*inputWidth +: inputWidth] = i_data;
          end
          if (wr_ptr_q == PTR_LAST) begin
            wr_ptr_d = '0;
            state_d  = EMIT;
            valid_d  = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      end
      EMIT: begin
        hold_cnt_d = '0;
        state_d    = (holdoffCycles == 0) ? COLLECT : HOLDOFF;
      end
      HOLDOFF: begin
        if (hold_cnt_q == CNT_LAST) state_d = COLLECT;
        else                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= COLLECT;
      wr_ptr_q     <= '0;
      hold_cnt_q   <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_ready      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      o_data       <= data_d;
      o_data_valid <= valid_d;
      o_ready      <= (state_d == COLLECT);
    end
  end

endmodule
